decode_operand_stage: RTL and testbench
=======================================

# decode_operand_stage

Decode/operand-fetch stage directly upstream of the register file's consumers and downstream of fetch.
- Takes the FD instruction, drives the register-file read pointers and receives the read data.
- Forwards in-flight results from the XM and W stages, detects RAW hazards and stalls fetch.
- Owns the DE pipeline register feeding execute.

## Interface
Parameters:
- INSN_SIZE, 16: instruction width. Fields: [15:12] opcode, [11:8] dst, [7:4] src_0, [3:0] src_1.
- REG_SIZE, `REG_SIZE: data width.
- REG_PTR_SIZE, `REG_PTR_SIZE: register pointer width, 4.

Ports:
- clk  in  1  clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- FD_valid  in  1  FD register holds an instruction.
- FD_insn  in  INSN_SIZE  fetched instruction.
- D_stall  out  1  fetch holds FD this cycle.
- FD_insn_src_0, FD_insn_src_1  out  REG_PTR_SIZE  register-file read pointers; combinational from FD_insn.
- D_src_0_data, D_src_1_data  in  REG_SIZE  register-file read data, same cycle.
- E_stall  in  1  execute cannot accept.
- XM_valid, XM_writes, XM_is_load  in  1 each  XM producer status.
- XM_dst  in  REG_PTR_SIZE;  XM_result  in  REG_SIZE.
- W_valid, W_writes  in  1 each;  W_dst  in  REG_PTR_SIZE;  W_result  in  REG_SIZE.
- DE_valid  out  1;  DE_insn  out  INSN_SIZE;  DE_src_0_data, DE_src_1_data  out  REG_SIZE.
- DE_dst  out  REG_PTR_SIZE;  DE_writes  out  1  DE instruction writes DE_dst.

## Operation
- Decode: opcode class gives is_F1 (writes dst), is_F2 (writes src_0), uses_src_0, uses_src_1.
  - Write pointer = dst when F1, src_0 when F2.
- Live producer = valid & writes. Match = live producer pointer equals a used source pointer.
- Hazard when FD_valid and any of:
  - match with DE (result not yet computed);
  - match with XM where XM_is_load.
- Forward priority per operand: XM_result (match, not load) > W_result (match) > D_src_*_data.
- D_stall = hazard | (DE_valid & E_stall).
- DE update each cycle:
  - E_stall & DE_valid: hold all DE outputs.
  - Otherwise, hazard or !FD_valid: bubble. DE_valid=0, DE_writes=0, other DE outputs unchanged.
  - Otherwise: load the decoded instruction, forwarded data and write pointer; DE_valid=1.
- Bubble with E_stall high and DE_valid=0: the stage still advances. Empty DE never blocks.

## Timing
- Reset (asynchronous assert, synchronous release edge): DE_valid=0, DE_writes=0, DE_insn=0, DE_dst=0, DE_src_*_data=0.
  - Reset mid-stall drops the held instruction.
- Latency: FD to DE is 1 cycle.
- DE-match hazard: 1 bubble. The producer reaches XM next cycle and is forwarded.
- XM load-use: 1 bubble. Forwarded from W next cycle.
- Hazard and E_stall together: DE holds, not bubbled. The hazard is re-evaluated next cycle.
- A write to register X in W on the same cycle X is read is served by forwarding, never by stale register-file data.

## Configuration
- DECODE_FORWARDING_EN defined: forwarding as described.
- Undefined: no forwarding muxes. Any match with a live DE, XM or W producer is a hazard. Operands come only from the register file.
  - Worst case: 3 bubbles behind a producer.

## Structure
- Shared package/header: field offsets, opcode localparams, class decode function (is_F1, is_F2, uses_src_*). The same decode is reused by the register-file write-select logic.
- Sub-module operand_forward, instantiated twice. Per operand it performs match, priority select and hazard output.

## Test plan
- Independent stream ADD R1 then ADD R2 (no overlap), E_stall=0 -> DE_valid=1 every cycle, D_stall never asserted.
- W writes R3=0x5A while FD reads R3, register file returns 0x00 -> DE_src_0_data=0x5A.
- XM load to R4 (XM_is_load=1), FD uses R4 -> D_stall=1 for 1 cycle, one bubble; next cycle DE_src data = W_result.
- XM writes R5=0x11 and W writes R5=0x22 together -> operand gets 0x11.
- E_stall=1 for 3 cycles with DE_valid=1 -> DE outputs constant, D_stall=1. Release -> next FD instruction loads.
- reset_n low mid-stall -> DE_valid=0 immediately, before the next clk edge.
- Without DECODE_FORWARDING_EN: W-match -> exactly 1 bubble.

Source files
------------

// File: rtl/decode_operand_stage_pkg.sv
// Shared decode definitions for the decode/operand-fetch stage and the register-file write-select logic.
// REG_SIZE may be overridden from the build; it defaults to 16 bits.
`ifndef REG_SIZE
`define REG_SIZE 16
`endif

package decode_operand_stage_pkg;

    localparam int INSN_SIZE_DEF    = 16;
    localparam int REG_SIZE_DEF     = `REG_SIZE;
    localparam int REG_PTR_SIZE_DEF = 4;

    localparam int OPC_LSB  = 12;
    localparam int DST_LSB  = 8;
    localparam int SRC0_LSB = 4;
    localparam int SRC1_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_ADDI  = 4'h5,
        OP_LOAD  = 4'h6,
        OP_STORE = 4'h7,
        OP_INC   = 4'h8,
        OP_MOVI  = 4'h9,
        OP_BRZ   = 4'hA
    } opcode_t;

    typedef struct packed {
        logic is_f1;
        logic is_f2;
        logic uses_src_0;
        logic uses_src_1;
    } insn_class_t;

    // F1 writes dst, F2 writes back into src_0; unlisted opcodes behave as NOP.
    function automatic insn_class_t decode_class(input logic [3:0] opcode);
        insn_class_t c;
        c = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: c = '{1'b1, 1'b0, 1'b1, 1'b1};
            OP_ADDI, OP_LOAD:              c = '{1'b1, 1'b0, 1'b1, 1'b0};
            OP_STORE:                      c = '{1'b0, 1'b0, 1'b1, 1'b1};
            OP_INC:                        c = '{1'b0, 1'b1, 1'b1, 1'b0};
            OP_MOVI:                       c = '{1'b0, 1'b1, 1'b0, 1'b0};
            OP_BRZ:                        c = '{1'b0, 1'b0, 1'b1, 1'b0};
            default:                       c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_operand_stage_if.sv
// Fetch, register-file, producer-status and DE pipeline signals of the decode/operand-fetch stage.
interface decode_operand_stage_if
    import decode_operand_stage_pkg::*;
#(
    parameter int INSN_SIZE    = INSN_SIZE_DEF,
    parameter int REG_SIZE     = REG_SIZE_DEF,
    parameter int REG_PTR_SIZE = REG_PTR_SIZE_DEF
) ();
    logic                    FD_valid;
    logic [INSN_SIZE-1:0]    FD_insn;
    logic                    D_stall;
    logic [REG_PTR_SIZE-1:0] FD_insn_src_0;
    logic [REG_PTR_SIZE-1:0] FD_insn_src_1;
    logic [REG_SIZE-1:0]     D_src_0_data;
    logic [REG_SIZE-1:0]     D_src_1_data;
    logic                    E_stall;
    logic                    XM_valid;
    logic                    XM_writes;
    logic                    XM_is_load;
    logic [REG_PTR_SIZE-1:0] XM_dst;
    logic [REG_SIZE-1:0]     XM_result;
    logic                    W_valid;
    logic                    W_writes;
    logic [REG_PTR_SIZE-1:0] W_dst;
    logic [REG_SIZE-1:0]     W_result;
    logic                    DE_valid;
    logic [INSN_SIZE-1:0]    DE_insn;
    logic [REG_SIZE-1:0]     DE_src_0_data;
    logic [REG_SIZE-1:0]     DE_src_1_data;
    logic [REG_PTR_SIZE-1:0] DE_dst;
    logic                    DE_writes;

    modport slave (
        input  FD_valid, FD_insn, D_src_0_data, D_src_1_data, E_stall,
               XM_valid, XM_writes, XM_is_load, XM_dst, XM_result,
               W_valid, W_writes, W_dst, W_result,
        output D_stall, FD_insn_src_0, FD_insn_src_1,
               DE_valid, DE_insn, DE_src_0_data, DE_src_1_data, DE_dst, DE_writes
    );

    modport master (
        output FD_valid, FD_insn, D_src_0_data, D_src_1_data, E_stall,
               XM_valid, XM_writes, XM_is_load, XM_dst, XM_result,
               W_valid, W_writes, W_dst, W_result,
        input  D_stall, FD_insn_src_0, FD_insn_src_1,
               DE_valid, DE_insn, DE_src_0_data, DE_src_1_data, DE_dst, DE_writes
    );
endinterface

// File: rtl/decode_operand_stage_operand_forward.sv
// Per-operand producer match, forwarding select and hazard flag.
// DECODE_FORWARDING_EN selects XM/W forwarding; without it every live match stalls.
module operand_forward
    import decode_operand_stage_pkg::*;
#(
    parameter int REG_SIZE     = REG_SIZE_DEF,
    parameter int REG_PTR_SIZE = REG_PTR_SIZE_DEF
) (
    input  logic [REG_PTR_SIZE-1:0] src,
    input  logic                    uses,
    input  logic                    de_live,
    input  logic [REG_PTR_SIZE-1:0] de_dst,
    input  logic                    xm_live,
    input  logic                    xm_is_load,
    input  logic [REG_PTR_SIZE-1:0] xm_dst,
    input  logic [REG_SIZE-1:0]     xm_result,
    input  logic                    w_live,
    input  logic [REG_PTR_SIZE-1:0] w_dst,
    input  logic [REG_SIZE-1:0]     w_result,
    input  logic [REG_SIZE-1:0]     rf_data,
    output logic [REG_SIZE-1:0]     data,
    output logic                    hazard
);
    logic de_match, xm_match, w_match;

    assign de_match = uses & de_live & (de_dst == src);
    assign xm_match = uses & xm_live & (xm_dst == src);
    assign w_match  = uses & w_live  & (w_dst  == src);

`ifdef DECODE_FORWARDING_EN
    // DE has no result yet and an XM load only has its data in W next cycle.
    assign hazard = de_match | (xm_match & xm_is_load);

    always_comb begin
        data = rf_data;
        if (xm_match && !xm_is_load) begin
            data = xm_result;
        end else if (w_match) begin
            data = w_result;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{xm_is_load, xm_result, w_result};

    assign hazard = de_match | xm_match | w_match;
    assign data   = rf_data;
`endif

endmodule

// File: rtl/decode_operand_stage.sv
// Decode/operand-fetch stage: register-file read pointers, RAW hazard stall and the DE pipeline register.
// Forwarding from XM/W is present only when DECODE_FORWARDING_EN is defined.
module decode_operand_stage
    import decode_operand_stage_pkg::*;
#(
    parameter int INSN_SIZE    = INSN_SIZE_DEF,
    parameter int REG_SIZE     = REG_SIZE_DEF,
    parameter int REG_PTR_SIZE = REG_PTR_SIZE_DEF
) (
    input logic                   clk,
    input logic                   reset_n,
    decode_operand_stage_if.slave pipe
);
    logic [3:0]              opcode;
    logic [REG_PTR_SIZE-1:0] dst, src_0, src_1, wr_ptr;
    insn_class_t             cls;
    logic                    de_live, xm_live, w_live;
    logic                    hazard_0, hazard_1, hazard, hold;
    logic [REG_SIZE-1:0]     fwd_0, fwd_1;

    logic                    de_valid_q, de_writes_q;
    logic [INSN_SIZE-1:0]    de_insn_q;
    logic [REG_PTR_SIZE-1:0] de_dst_q;
    logic [REG_SIZE-1:0]     de_src_0_q, de_src_1_q;

    assign opcode = pipe.FD_insn[OPC_LSB +: 4];
    assign dst    = pipe.FD_insn[DST_LSB +: REG_PTR_SIZE];
    assign src_0  = pipe.FD_insn[SRC0_LSB +: REG_PTR_SIZE];
    assign src_1  = pipe.FD_insn[SRC1_LSB +: REG_PTR_SIZE];
    assign cls    = decode_class(opcode);
    assign wr_ptr = cls.is_f2 ? src_0 : dst;

    assign pipe.FD_insn_src_0 = src_0;
    assign pipe.FD_insn_src_1 = src_1;

    assign de_live = de_valid_q & de_writes_q;
    assign xm_live = pipe.XM_valid & pipe.XM_writes;
    assign w_live  = pipe.W_valid & pipe.W_writes;

    operand_forward #(.REG_SIZE(REG_SIZE), .REG_PTR_SIZE(REG_PTR_SIZE)) u_fwd_0 (
        .src(src_0), .uses(cls.uses_src_0),
        .de_live(de_live), .de_dst(de_dst_q),
        .xm_live(xm_live), .xm_is_load(pipe.XM_is_load), .xm_dst(pipe.XM_dst), .xm_result(pipe.XM_result),
        .w_live(w_live), .w_dst(pipe.W_dst), .w_result(pipe.W_result),
        .rf_data(pipe.D_src_0_data), .data(fwd_0), .hazard(hazard_0)
    );

    operand_forward #(.REG_SIZE(REG_SIZE), .REG_PTR_SIZE(REG_PTR_SIZE)) u_fwd_1 (
        .src(src_1), .uses(cls.uses_src_1),
        .de_live(de_live), .de_dst(de_dst_q),
        .xm_live(xm_live), .xm_is_load(pipe.XM_is_load), .xm_dst(pipe.XM_dst), .xm_result(pipe.XM_result),
        .w_live(w_live), .w_dst(pipe.W_dst), .w_result(pipe.W_result),
        .rf_data(pipe.D_src_1_data), .data(fwd_1), .hazard(hazard_1)
    );

    // An empty DE never blocks, so E_stall alone only holds a valid entry.
    assign hazard       = pipe.FD_valid & (hazard_0 | hazard_1);
    assign hold         = de_valid_q & pipe.E_stall;
    assign pipe.D_stall = hazard | hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de_valid_q  <= 1'b0;
            de_writes_q <= 1'b0;
            de_insn_q   <= '0;
            de_dst_q    <= '0;
            de_src_0_q  <= '0;
            de_src_1_q  <= '0;
        end else if (!hold) begin
            if (hazard || !pipe.FD_valid) begin
                de_valid_q  <= 1'b0;
                de_writes_q <= 1'b0;
            end else begin
                de_valid_q  <= 1'b1;
                de_writes_q <= cls.is_f1 | cls.is_f2;
                de_insn_q   <= pipe.FD_insn;
                de_dst_q    <= wr_ptr;
                de_src_0_q  <= fwd_0;
                de_src_1_q  <= fwd_1;
            end
        end
    end

    assign pipe.DE_valid      = de_valid_q;
    assign pipe.DE_writes     = de_writes_q;
    assign pipe.DE_insn       = de_insn_q;
    assign pipe.DE_dst        = de_dst_q;
    assign pipe.DE_src_0_data = de_src_0_q;
    assign pipe.DE_src_1_data = de_src_1_q;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Bench for decode_operand_stage: directed scenarios plus random traffic against a reference model.
module tb_decode_operand_stage;
    import decode_operand_stage_pkg::*;

    localparam int RW = REG_SIZE_DEF;
`ifdef DECODE_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    decode_operand_stage_if bus ();

    decode_operand_stage dut (.clk(clk), .reset_n(reset_n), .pipe(bus.slave));

    int n_cmp = 0;
    int n_mis = 0;

    // opcode -> {writes dst, writes src_0, reads src_0, reads src_1}
    bit [3:0] cls_tbl [16];

    logic          m_valid, m_writes;
    logic [15:0]   m_insn;
    logic [3:0]    m_dst;
    logic [RW-1:0] m_d0, m_d1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int op, input int d, input int s0, input int s1);
        return {op[3:0], d[3:0], s0[3:0], s1[3:0]};
    endfunction

    // Returns {stall_needed, operand_value} for one source of the FD instruction.
    function automatic logic [RW:0] eval_src(input logic [3:0] src, input bit used, input logic [RW-1:0] rf);
        bit de_hit, xm_hit, w_hit, hz;
        logic [RW-1:0] v;
        de_hit = used && m_valid && m_writes && (m_dst == src);
        xm_hit = used && bus.XM_valid && bus.XM_writes && (bus.XM_dst == src);
        w_hit  = used && bus.W_valid && bus.W_writes && (bus.W_dst == src);
        v = rf;
        if (FWD) begin
            hz = de_hit || (xm_hit && bus.XM_is_load);
            if (xm_hit && !bus.XM_is_load) v = bus.XM_result;
            else if (w_hit) v = bus.W_result;
        end else begin
            hz = de_hit || xm_hit || w_hit;
        end
        return {hz, v};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_writes = 0; m_insn = '0; m_dst = '0; m_d0 = '0; m_d1 = '0;
    endtask

    task automatic check_de();
        check_val("de_valid", bus.DE_valid, m_valid);
        check_val("de_writes", bus.DE_writes, m_writes);
        check_val("de_insn", bus.DE_insn, m_insn);
        check_val("de_dst", bus.DE_dst, m_dst);
        check_val("de_src_0", bus.DE_src_0_data, m_d0);
        check_val("de_src_1", bus.DE_src_1_data, m_d1);
    endtask

    task automatic set_idle();
        bus.FD_valid = 0; bus.FD_insn = '0; bus.E_stall = 0;
        bus.D_src_0_data = '0; bus.D_src_1_data = '0;
        bus.XM_valid = 0; bus.XM_writes = 0; bus.XM_is_load = 0; bus.XM_dst = '0; bus.XM_result = '0;
        bus.W_valid = 0; bus.W_writes = 0; bus.W_dst = '0; bus.W_result = '0;
    endtask

    // Inputs are already applied; predict, clock once, then compare DE.
    task automatic tick();
        logic [15:0] insn;
        bit [3:0] f;
        logic [RW:0] r0, r1;
        bit hazard, hold;
        #1;
        insn = bus.FD_insn;
        f = cls_tbl[insn[15:12]];
        r0 = eval_src(insn[7:4], f[1], bus.D_src_0_data);
        r1 = eval_src(insn[3:0], f[0], bus.D_src_1_data);
        hazard = bus.FD_valid && (r0[RW] || r1[RW]);
        hold = m_valid && bus.E_stall;
        check_val("d_stall", bus.D_stall, hazard || hold);
        check_val("rd_ptr_0", bus.FD_insn_src_0, insn[7:4]);
        check_val("rd_ptr_1", bus.FD_insn_src_1, insn[3:0]);
        if (!hold) begin
            if (hazard || !bus.FD_valid) begin
                m_valid = 0; m_writes = 0;
            end else begin
                m_valid = 1;
                m_writes = f[3] || f[2];
                m_insn = insn;
                m_dst = f[2] ? insn[7:4] : insn[11:8];
                m_d0 = r0[RW-1:0];
                m_d1 = r1[RW-1:0];
            end
        end
        @(posedge clk);
        #1;
        check_de();
    endtask

    task automatic rand_inputs();
        bus.FD_valid = $urandom_range(0, 7) != 0;
        bus.FD_insn = mk($urandom_range(0, 11), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        bus.E_stall = $urandom_range(0, 3) == 0;
        bus.D_src_0_data = RW'($urandom);
        bus.D_src_1_data = RW'($urandom);
        bus.XM_valid = 1'($urandom);
        bus.XM_writes = 1'($urandom);
        bus.XM_is_load = $urandom_range(0, 2) == 0;
        bus.XM_dst = 4'($urandom_range(0, 3));
        bus.XM_result = RW'($urandom);
        bus.W_valid = 1'($urandom);
        bus.W_writes = 1'($urandom);
        bus.W_dst = 4'($urandom_range(0, 3));
        bus.W_result = RW'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) cls_tbl[i] = 4'b0000;
        for (int i = 1; i <= 4; i++) cls_tbl[i] = 4'b1011;
        cls_tbl[5] = 4'b1010; cls_tbl[6] = 4'b1010;
        cls_tbl[7] = 4'b0011; cls_tbl[8] = 4'b0110;
        cls_tbl[9] = 4'b0100; cls_tbl[10] = 4'b0010;

        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_de();
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;

        // Independent ADD R1 then ADD R2.
        bus.FD_valid = 1;
        bus.FD_insn = mk(1, 1, 6, 7); tick();
        bus.FD_insn = mk(1, 2, 8, 9); tick();
        bus.FD_insn = mk(2, 10, 11, 12); tick();

        // W writes R3 while FD reads R3 with stale register-file data.
        set_idle(); tick();
        bus.FD_valid = 1; bus.FD_insn = mk(1, 10, 3, 4);
        bus.W_valid = 1; bus.W_writes = 1; bus.W_dst = 3; bus.W_result = RW'(16'h5A);
        tick(); tick();
        set_idle(); tick(); tick();

        // XM load to R4 followed by a use; next cycle the load data arrives from W.
        bus.FD_valid = 1; bus.FD_insn = mk(1, 11, 4, 5);
        bus.XM_valid = 1; bus.XM_writes = 1; bus.XM_is_load = 1; bus.XM_dst = 4;
        tick();
        bus.XM_valid = 0; bus.W_valid = 1; bus.W_writes = 1; bus.W_dst = 4; bus.W_result = RW'(16'h77);
        tick();
        set_idle(); tick(); tick();

        // XM and W both write R5.
        bus.FD_valid = 1; bus.FD_insn = mk(3, 12, 5, 5);
        bus.XM_valid = 1; bus.XM_writes = 1; bus.XM_dst = 5; bus.XM_result = RW'(16'h11);
        bus.W_valid = 1; bus.W_writes = 1; bus.W_dst = 5; bus.W_result = RW'(16'h22);
        tick(); tick();
        set_idle(); tick(); tick(); tick();

        // E_stall for 3 cycles with a valid DE entry, then release.
        bus.FD_valid = 1; bus.FD_insn = mk(1, 1, 6, 7); tick();
        bus.FD_insn = mk(1, 2, 8, 9); bus.E_stall = 1;
        repeat (3) tick();
        bus.E_stall = 0; tick();

        // Reset asserted mid-stall clears DE without waiting for a clock edge.
        bus.E_stall = 1; tick();
        #2;
        reset_n = 0;
        #1;
        model_reset();
        check_val("rst_async_valid", bus.DE_valid, 1'b0);
        check_val("rst_async_insn", bus.DE_insn, 16'h0);
        set_idle();
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
        check_de();

        repeat (2000) begin
            rand_inputs();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
